// File: rtl/axi4_master_burst_engine.sv
// AXI4 master traffic engine: writes INCR bursts of a counting pattern, then reads the region back.
// Latency: AWVALID/BUSY one cycle after BEGIN_TEST; DONE one cycle after the final B or R handshake.
// Backpressure: one outstanding burst; every VALID and payload is registered and held until READY.
// Optional feature macro: AXI4_MASTER_DATA_CHECK_EN (compare every RDATA beat with the pattern).
module axi4_master_burst_engine #(
    parameter logic [31:0] P_TARGET_SLAVE_BASE_ADDR = 32'h1000_0000,
    parameter int          P_WRITE_BURSTS           = 1,
    parameter int          P_READ_BURSTS            = 16,
    parameter int          P_BURST_LEN              = 16,
    parameter int          P_ID_WIDTH               = 6,
    parameter int          P_ADDR_WIDTH             = 32,
    parameter int          P_DATA_WIDTH             = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_begin_test,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic [15:0]               o_err_count,
    output logic [P_ID_WIDTH-1:0]     o_m_axi_awid,
    output logic [P_ADDR_WIDTH-1:0]   o_m_axi_awaddr,
    output logic [7:0]                o_m_axi_awlen,
    output logic [2:0]                o_m_axi_awsize,
    output logic [1:0]                o_m_axi_awburst,
    output logic                      o_m_axi_awvalid,
    input  logic                      i_m_axi_awready,
    output logic [P_DATA_WIDTH-1:0]   o_m_axi_wdata,
    output logic [P_DATA_WIDTH/8-1:0] o_m_axi_wstrb,
    output logic                      o_m_axi_wlast,
    output logic                      o_m_axi_wvalid,
    input  logic                      i_m_axi_wready,
    input  logic [P_ID_WIDTH-1:0]     i_m_axi_bid,
    input  logic [1:0]                i_m_axi_bresp,
    input  logic                      i_m_axi_bvalid,
    output logic                      o_m_axi_bready,
    output logic [P_ID_WIDTH-1:0]     o_m_axi_arid,
    output logic [P_ADDR_WIDTH-1:0]   o_m_axi_araddr,
    output logic [7:0]                o_m_axi_arlen,
    output logic [2:0]                o_m_axi_arsize,
    output logic [1:0]                o_m_axi_arburst,
    output logic                      o_m_axi_arvalid,
    input  logic                      i_m_axi_arready,
    input  logic [P_ID_WIDTH-1:0]     i_m_axi_rid,
    input  logic [P_DATA_WIDTH-1:0]   i_m_axi_rdata,
    input  logic [1:0]                i_m_axi_rresp,
    input  logic                      i_m_axi_rlast,
    input  logic                      i_m_axi_rvalid,
    output logic                      o_m_axi_rready
);

    localparam int                      LP_LANES       = P_DATA_WIDTH / 32;
    localparam logic [7:0]              LP_LAST        = 8'(P_BURST_LEN - 1);
    localparam logic [2:0]              LP_SIZE        = 3'($clog2(P_DATA_WIDTH / 8));
    localparam logic [31:0]             LP_WR_N        = 32'(P_WRITE_BURSTS);
    localparam logic [31:0]             LP_RD_N        = 32'(P_READ_BURSTS);
    localparam logic [P_ADDR_WIDTH-1:0] LP_BASE        = P_ADDR_WIDTH'(P_TARGET_SLAVE_BASE_ADDR);
    localparam logic [P_ADDR_WIDTH-1:0] LP_BURST_BYTES = P_ADDR_WIDTH'(P_BURST_LEN * (P_DATA_WIDTH / 8));

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    // Pattern of global beat 0: lane j holds j.
    function automatic logic [P_DATA_WIDTH-1:0] f_first_pattern();
        logic [P_DATA_WIDTH-1:0] v;
        v = '0;
        for (int j = 0; j < LP_LANES; j++) v[j*32 +: 32] = 32'(j);
        return v;
    endfunction

    // Pattern of the following global beat: every lane advances by the lane count.
    function automatic logic [P_DATA_WIDTH-1:0] f_next_pattern(input logic [P_DATA_WIDTH-1:0] v);
        logic [P_DATA_WIDTH-1:0] n;
        n = v;
        for (int j = 0; j < LP_LANES; j++) n[j*32 +: 32] = v[j*32 +: 32] + 32'(LP_LANES);
        return n;
    endfunction

    state_t                    r_state;
    logic                      r_busy, r_done, r_error;
    logic [15:0]               r_err_count;
    logic [31:0]               r_wr_burst, r_rd_burst, r_rd_src;
    logic [7:0]                r_beat;
    logic                      r_awvalid, r_wvalid, r_wlast, r_bready, r_arvalid, r_rready;
    logic [P_ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
    logic [7:0]                r_len;
    logic [2:0]                r_size;
    logic [1:0]                r_burst;
    logic [P_DATA_WIDTH-1:0]   r_wdata;
    logic [P_DATA_WIDTH/8-1:0] r_wstrb;

    logic        w_start, w_r_hs, w_rresp_err, w_rlast_err, w_data_err;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;
    logic [15:0] w_err_next;

    assign w_start     = i_begin_test && (r_state == S_IDLE || r_state == S_DONE);
    assign w_r_hs      = (r_state == S_RD_DATA) && i_m_axi_rvalid && r_rready;
    assign w_rresp_err = (i_m_axi_rresp != 2'b00);
    assign w_rlast_err = (i_m_axi_rlast != (r_beat == LP_LAST));

`ifdef AXI4_MASTER_DATA_CHECK_EN
    logic [P_DATA_WIDTH-1:0] r_exp;
    logic                    w_unused;
    assign w_data_err = (i_m_axi_rdata != r_exp);
    assign w_unused   = ^{i_m_axi_rid, i_m_axi_bid};

    // Expected read pattern follows the write burst being read back; rewinds when the source wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_exp <= '0;
        end else if (w_start) begin
            r_exp <= f_first_pattern();
        end else if (w_r_hs) begin
            if (r_beat == LP_LAST && r_rd_src + 32'd1 == LP_WR_N) r_exp <= f_first_pattern();
            else                                                   r_exp <= f_next_pattern(r_exp);
        end
    end
`else
    logic w_unused;
    assign w_data_err = 1'b0;
    assign w_unused   = ^{i_m_axi_rdata, i_m_axi_rid, i_m_axi_bid};
`endif

    // Number of error events seen this cycle; several can coincide on one R beat.
    always_comb begin
        w_err_inc = 2'd0;
        if (r_state == S_WR_RESP && i_m_axi_bvalid && r_bready && i_m_axi_bresp != 2'b00)
            w_err_inc = 2'd1;
        if (w_r_hs)
            w_err_inc = {1'b0, w_rresp_err} + {1'b0, w_rlast_err} + {1'b0, w_data_err};
        w_err_sum  = {1'b0, r_err_count} + {15'd0, w_err_inc};
        w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end

    // Test sequencer: write bursts, then read bursts, one transaction in flight, all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= 16'd0;
            r_wr_burst  <= 32'd0;
            r_rd_burst  <= 32'd0;
            r_rd_src    <= 32'd0;
            r_beat      <= 8'd0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_len       <= 8'd0;
            r_size      <= 3'd0;
            r_burst     <= 2'd0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
        end else begin
            if (w_err_inc != 2'd0) begin
                r_err_count <= w_err_next;
                r_error     <= 1'b1;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_begin_test) begin
                        r_state     <= S_WR_ADDR;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_err_count <= 16'd0;
                        r_wr_burst  <= 32'd0;
                        r_rd_burst  <= 32'd0;
                        r_rd_src    <= 32'd0;
                        r_beat      <= 8'd0;
                        r_awvalid   <= 1'b1;
                        r_awaddr    <= LP_BASE;
                        r_len       <= LP_LAST;
                        r_size      <= LP_SIZE;
                        r_burst     <= 2'b01;
                        r_wstrb     <= '1;
                        r_wdata     <= f_first_pattern();
                    end
                end
                S_WR_ADDR: begin
                    if (i_m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wlast   <= (LP_LAST == 8'd0);
                        r_beat    <= 8'd0;
                        r_state   <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (i_m_axi_wready) begin
                        r_wdata <= f_next_pattern(r_wdata);
                        if (r_beat == LP_LAST) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= S_WR_RESP;
                        end else begin
                            r_beat  <= r_beat + 8'd1;
                            r_wlast <= (r_beat + 8'd1 == LP_LAST);
                        end
                    end
                end
                S_WR_RESP: begin
                    if (i_m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (r_wr_burst + 32'd1 < LP_WR_N) begin
                            r_wr_burst <= r_wr_burst + 32'd1;
                            r_awaddr   <= r_awaddr + LP_BURST_BYTES;
                            r_awvalid  <= 1'b1;
                            r_state    <= S_WR_ADDR;
                        end else if (LP_RD_N != 32'd0) begin
                            r_araddr  <= LP_BASE;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (i_m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= 8'd0;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (i_m_axi_rvalid) begin
                        if (r_beat == LP_LAST) begin
                            r_rready <= 1'b0;
                            if (r_rd_burst + 32'd1 < LP_RD_N) begin
                                r_rd_burst <= r_rd_burst + 32'd1;
                                // Read burst k revisits write burst k mod P_WRITE_BURSTS.
                                if (r_rd_src + 32'd1 == LP_WR_N) begin
                                    r_rd_src <= 32'd0;
                                    r_araddr <= LP_BASE;
                                end else begin
                                    r_rd_src <= r_rd_src + 32'd1;
                                    r_araddr <= r_araddr + LP_BURST_BYTES;
                                end
                                r_arvalid <= 1'b1;
                                r_state   <= S_RD_ADDR;
                            end else begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_beat <= r_beat + 8'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_error         = r_error;
    assign o_err_count     = r_err_count;
    assign o_m_axi_awid    = '0;
    assign o_m_axi_awaddr  = r_awaddr;
    assign o_m_axi_awlen   = r_len;
    assign o_m_axi_awsize  = r_size;
    assign o_m_axi_awburst = r_burst;
    assign o_m_axi_awvalid = r_awvalid;
    assign o_m_axi_wdata   = r_wdata;
    assign o_m_axi_wstrb   = r_wstrb;
    assign o_m_axi_wlast   = r_wlast;
    assign o_m_axi_wvalid  = r_wvalid;
    assign o_m_axi_bready  = r_bready;
    assign o_m_axi_arid    = '0;
    assign o_m_axi_araddr  = r_araddr;
    assign o_m_axi_arlen   = r_len;
    assign o_m_axi_arsize  = r_size;
    assign o_m_axi_arburst = r_burst;
    assign o_m_axi_arvalid = r_arvalid;
    assign o_m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi4_master_burst_engine.sv
// Bench for axi4_master_burst_engine: randomized AXI slave with memory, pattern and address reference.
// Engine configured with 4 write bursts, 6 read bursts, 16 beats, 64-bit data.
// Slave stalls are random per run; injected slave errors define the expected error count.
`timescale 1ns/1ps
module tb_axi4_master_burst_engine;

    localparam int          TW     = 4;
    localparam int          TR     = 6;
    localparam int          TLEN   = 16;
    localparam int          TDW    = 64;
    localparam int          TL     = TDW / 32;
    localparam int          TBYTES = TDW / 8;
    localparam int          TIDW   = 6;
    localparam logic [31:0] TBASE  = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic begin_test = 1'b0;

    logic            busy, done, error;
    logic [15:0]     err_count;
    logic [TIDW-1:0] awid, arid, bid, rid;
    logic [31:0]     awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst;
    logic            awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [TDW-1:0]  wdata;
    logic [TDW/8-1:0] wstrb;

    logic           s_awready = 0, s_wready = 0, s_bvalid = 0, s_arready = 0, s_rvalid = 0, s_rlast = 0;
    logic [1:0]     s_bresp = 0, s_rresp = 0;
    logic [TDW-1:0] s_rdata = 0;

    initial forever #5 clk = ~clk;

    axi4_master_burst_engine #(
        .P_TARGET_SLAVE_BASE_ADDR(TBASE), .P_WRITE_BURSTS(TW), .P_READ_BURSTS(TR),
        .P_BURST_LEN(TLEN), .P_ID_WIDTH(TIDW), .P_ADDR_WIDTH(32), .P_DATA_WIDTH(TDW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_begin_test(begin_test),
        .o_busy(busy), .o_done(done), .o_error(error), .o_err_count(err_count),
        .o_m_axi_awid(awid), .o_m_axi_awaddr(awaddr), .o_m_axi_awlen(awlen), .o_m_axi_awsize(awsize),
        .o_m_axi_awburst(awburst), .o_m_axi_awvalid(awvalid), .i_m_axi_awready(s_awready),
        .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb), .o_m_axi_wlast(wlast), .o_m_axi_wvalid(wvalid),
        .i_m_axi_wready(s_wready),
        .i_m_axi_bid(bid), .i_m_axi_bresp(s_bresp), .i_m_axi_bvalid(s_bvalid), .o_m_axi_bready(bready),
        .o_m_axi_arid(arid), .o_m_axi_araddr(araddr), .o_m_axi_arlen(arlen), .o_m_axi_arsize(arsize),
        .o_m_axi_arburst(arburst), .o_m_axi_arvalid(arvalid), .i_m_axi_arready(s_arready),
        .i_m_axi_rid(rid), .i_m_axi_rdata(s_rdata), .i_m_axi_rresp(s_rresp), .i_m_axi_rlast(s_rlast),
        .i_m_axi_rvalid(s_rvalid), .o_m_axi_rready(rready)
    );

    assign bid = '0;
    assign rid = '0;

    int checks = 0, failures = 0;
    bit stall = 0;
    int inj_bresp = -1, inj_rlast = -1, inj_rresp = -1, inj_corrupt = -1;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic [TDW-1:0] mem [int];

    // Slave model: all decisions at negedge; a handshake seen here completes at the next posedge.
    task automatic slave_loop();
        bit b_pending = 0, b_hs_pend = 0, r_hs_pend = 0, aw_hs_prev = 0, done_pend = 0;
        bit p_aw = 0, p_w = 0, p_ar = 0;
        logic [31:0] p_awaddr = 0, p_araddr = 0, ea;
        logic [TDW-1:0] p_wdata = 0, ed;
        logic p_wlast = 0;
        int r_left = 0, r_beat = 0, r_idx = 0, wb;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0; s_arready = 0;
                s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0;
                b_pending = 0; b_hs_pend = 0; r_hs_pend = 0; aw_hs_prev = 0; done_pend = 0;
                p_aw = 0; p_w = 0; p_ar = 0; r_left = 0;
            end else begin
                if (b_hs_pend) begin s_bvalid = 0; b_hs_pend = 0; end
                if (r_hs_pend) begin s_rvalid = 0; r_beat++; r_left--; r_hs_pend = 0; end
                if (aw_hs_prev) begin
                    checks++;
                    if (wvalid !== 1'b1) begin failures++; $display("FAIL wvalid_after_aw: got %b want 1", wvalid); end
                    aw_hs_prev = 0;
                end
                if (done_pend) begin
                    checks++;
                    if ({done, busy} !== 2'b10) begin failures++; $display("FAIL done_timing: done,busy=%b want 10", {done, busy}); end
                    done_pend = 0;
                end
                if (p_aw) begin
                    checks++;
                    if (awvalid !== 1'b1 || awaddr !== p_awaddr) begin failures++; $display("FAIL aw_stable: valid=%b addr=%h want 1 %h", awvalid, awaddr, p_awaddr); end
                end
                if (p_w) begin
                    checks++;
                    if (wvalid !== 1'b1 || wdata !== p_wdata || wlast !== p_wlast) begin failures++; $display("FAIL w_stable: valid=%b data=%h want 1 %h", wvalid, wdata, p_wdata); end
                end
                if (p_ar) begin
                    checks++;
                    if (arvalid !== 1'b1 || araddr !== p_araddr) begin failures++; $display("FAIL ar_stable: valid=%b addr=%h want 1 %h", arvalid, araddr, p_araddr); end
                end
                s_awready = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
                s_wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                s_arready = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
                if (b_pending && !s_bvalid && (!stall || $urandom_range(0, 2) == 0)) begin
                    s_bvalid = 1; s_bresp = (b_cnt == inj_bresp) ? 2'b10 : 2'b00; b_pending = 0;
                end
                if (r_left > 0 && !s_rvalid && (!stall || $urandom_range(0, 2) == 0)) begin
                    s_rvalid = 1;
                    s_rdata  = mem.exists(r_idx + r_beat) ? mem[r_idx + r_beat] : '0;
                    if (ar_cnt - 1 == inj_corrupt && r_beat == 7) s_rdata = s_rdata ^ 64'h20;
                    s_rlast  = (r_beat == TLEN - 1) && (ar_cnt - 1 != inj_rlast);
                    s_rresp  = (ar_cnt - 1 == inj_rresp && r_beat == 2) ? 2'b10 : 2'b00;
                end
                if (awvalid && s_awready) begin
                    ea = TBASE + 32'(aw_cnt * TLEN * TBYTES);
                    checks++;
                    if (awaddr !== ea) begin failures++; $display("FAIL aw_addr: got %h want %h", awaddr, ea); end
                    checks++;
                    if ({awid, awlen, awsize, awburst} !== {6'd0, 8'(TLEN - 1), 3'd3, 2'b01})
                        begin failures++; $display("FAIL aw_fields: len=%0d size=%0d burst=%0d want %0d 3 1", awlen, awsize, awburst, TLEN - 1); end
                    aw_cnt++; aw_hs_prev = 1;
                end
                if (wvalid && s_wready) begin
                    wb = w_cnt % TLEN;
                    for (int j = 0; j < TL; j++) ed[j*32 +: 32] = 32'(w_cnt * TL + j);
                    checks++;
                    if (wdata !== ed || wstrb !== '1) begin failures++; $display("FAIL w_data: got %h/%h want %h/ff", wdata, wstrb, ed); end
                    checks++;
                    if (wlast !== (wb == TLEN - 1) || w_cnt >= aw_cnt * TLEN) begin failures++; $display("FAIL w_last: got %b beat %0d aws %0d", wlast, wb, aw_cnt); end
                    mem[w_cnt] = wdata;
                    w_cnt++;
                    if (wb == TLEN - 1) b_pending = 1;
                end
                if (s_bvalid && bready) begin b_cnt++; b_hs_pend = 1; end
                if (arvalid && s_arready) begin
                    ea = TBASE + 32'((ar_cnt % TW) * TLEN * TBYTES);
                    checks++;
                    if (araddr !== ea || {arid, arlen, arsize, arburst} !== {6'd0, 8'(TLEN - 1), 3'd3, 2'b01})
                        begin failures++; $display("FAIL ar_addr: got %h len %0d want %h %0d", araddr, arlen, ea, TLEN - 1); end
                    r_left = TLEN; r_beat = 0; r_idx = int'((araddr - TBASE) / TBYTES);
                    ar_cnt++;
                end
                if (s_rvalid && rready) begin
                    r_cnt++; r_hs_pend = 1;
                    if (ar_cnt == TR && r_beat == TLEN - 1) done_pend = 1;
                end
                p_aw = awvalid && !s_awready; p_awaddr = awaddr;
                p_w  = wvalid && !s_wready;   p_wdata = wdata; p_wlast = wlast;
                p_ar = arvalid && !s_arready; p_araddr = araddr;
            end
        end
    endtask

    task automatic start_run(input bit st, input int eb, input int el, input int er, input int ec);
        @(negedge clk); #1;
        stall = st; inj_bresp = eb; inj_rlast = el; inj_rresp = er; inj_corrupt = ec;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        begin_test = 1;
        @(negedge clk); #1;
        begin_test = 0;
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 20000; n++) begin
            @(negedge clk); #1;
            if (done === 1'b1) break;
        end
        if (n == 20000) begin checks++; failures++; $display("FAIL done_timeout: done=%b want 1", done); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk); #1;
        checks++;
        if ({busy, done, error, err_count, awvalid, awaddr, awlen, awsize, awburst, wvalid, wdata, wstrb,
             wlast, bready, arvalid, araddr, arlen, arsize, arburst, rready} !== '0)
            begin failures++; $display("FAIL reset_outputs: busy=%b awv=%b wdata=%h want all 0", busy, awvalid, wdata); end
        rst_n = 1;
        repeat (3) @(negedge clk); #1;
        checks++;
        if ({busy, done, awvalid} !== 3'b000) begin failures++; $display("FAIL idle_after_reset: %b want 000", {busy, done, awvalid}); end
    endtask

    task automatic test_basic();
        start_run(0, -1, -1, -1, -1);
        checks++;
        if ({busy, awvalid, done} !== 3'b110) begin failures++; $display("FAIL start_latency: busy,awv,done=%b want 110", {busy, awvalid, done}); end
        wait_done();
        checks++;
        if ({aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} !== {TW, TW * TLEN, TW, TR, TR * TLEN})
            begin failures++; $display("FAIL basic_counts: aw%0d w%0d b%0d ar%0d r%0d want %0d %0d %0d %0d %0d", aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, TW, TW*TLEN, TW, TR, TR*TLEN); end
        checks++;
        if ({busy, error, err_count} !== 18'd0) begin failures++; $display("FAIL basic_status: busy=%b err=%b cnt=%0d want 0 0 0", busy, error, err_count); end
    endtask

    task automatic test_stalls();
        start_run(1, -1, -1, -1, -1);
        wait_done();
        checks++;
        if ({aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} !== {TW, TW * TLEN, TW, TR, TR * TLEN})
            begin failures++; $display("FAIL stall_counts: aw%0d w%0d ar%0d r%0d", aw_cnt, w_cnt, ar_cnt, r_cnt); end
        checks++;
        if ({error, err_count} !== 17'd0) begin failures++; $display("FAIL stall_status: err=%b cnt=%0d want 0 0", error, err_count); end
    endtask

    task automatic test_errors();
        int exp_cnt;
`ifdef AXI4_MASTER_DATA_CHECK_EN
        exp_cnt = 2;
`else
        exp_cnt = 1;
`endif
        start_run(1, 1, -1, -1, 2);
        wait_done();
        checks++;
        if (error !== 1'b1 || err_count !== 16'(exp_cnt)) begin failures++; $display("FAIL bresp_corrupt: err=%b cnt=%0d want 1 %0d", error, err_count, exp_cnt); end
    endtask

    task automatic test_rlast();
        start_run(1, -1, 3, -1, -1);
        wait_done();
        checks++;
        if (error !== 1'b1 || err_count !== 16'd1 || r_cnt != TR * TLEN) begin failures++; $display("FAIL missing_rlast: err=%b cnt=%0d beats=%0d want 1 1 %0d", error, err_count, r_cnt, TR*TLEN); end
        start_run(0, -1, -1, 5, -1);
        wait_done();
        checks++;
        if (error !== 1'b1 || err_count !== 16'd1) begin failures++; $display("FAIL rresp: err=%b cnt=%0d want 1 1", error, err_count); end
    endtask

    task automatic test_reset_mid();
        int n;
        start_run(0, -1, -1, -1, -1);
        for (n = 0; n < 200; n++) begin
            @(negedge clk); #1;
            if (w_cnt >= 3 && wvalid === 1'b1) break;
        end
        checks++;
        if (n == 200) begin failures++; $display("FAIL reach_wr_data: w_cnt=%0d want >=3", w_cnt); end
        #1 rst_n = 0;
        #1;
        checks++;
        if ({busy, done, error, err_count, awvalid, wvalid, wdata, wlast, bready, arvalid, rready} !== '0)
            begin failures++; $display("FAIL reset_mid: busy=%b wvalid=%b wdata=%h want all 0", busy, wvalid, wdata); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1;
        start_run(0, -1, -1, -1, -1);
        wait_done();
        checks++;
        if ({aw_cnt, r_cnt, err_count} !== {TW, TR * TLEN, 16'd0}) begin failures++; $display("FAIL restart: aw%0d r%0d cnt=%0d want %0d %0d 0", aw_cnt, r_cnt, err_count, TW, TR*TLEN); end
    endtask

    task automatic test_busy_ignore();
        start_run(1, -1, -1, -1, -1);
        repeat (20) @(negedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_mid: got %b want 1", busy); end
        begin_test = 1;
        @(negedge clk); #1;
        begin_test = 0;
        wait_done();
        checks++;
        if ({aw_cnt, w_cnt, ar_cnt, r_cnt} !== {TW, TW * TLEN, TR, TR * TLEN}) begin failures++; $display("FAIL busy_ignore: aw%0d w%0d ar%0d r%0d", aw_cnt, w_cnt, ar_cnt, r_cnt); end
    endtask

    task automatic test_rerun();
        repeat (5) @(negedge clk); #1;
        checks++;
        if ({done, busy} !== 2'b10) begin failures++; $display("FAIL done_held: done,busy=%b want 10", {done, busy}); end
        start_run(1, 0, -1, -1, -1);
        checks++;
        if ({done, busy, awvalid} !== 3'b011) begin failures++; $display("FAIL rerun_start: done,busy,awv=%b want 011", {done, busy, awvalid}); end
        wait_done();
        checks++;
        if ({aw_cnt, r_cnt, error, err_count} !== {TW, TR * TLEN, 1'b1, 16'd1}) begin failures++; $display("FAIL rerun_status: aw%0d r%0d err=%b cnt=%0d want %0d %0d 1 1", aw_cnt, r_cnt, error, err_count, TW, TR*TLEN); end
    endtask

    initial begin
        fork
            slave_loop();
        join_none
        test_reset();
        test_basic();
        test_stalls();
        test_errors();
        test_rlast();
        test_reset_mid();
        test_busy_ignore();
        test_rerun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
